// File: rtl/calc_accumulator_if.sv
// Board-side bus of the accumulator calculator: strobe, operation buttons,
// switch operand and LED readback. The board/bench drives the master side.
interface calc_accumulator_if;
  logic        btnd;  // accumulator update strobe
  logic        btnl;  // operation select bit 2
  logic        btnc;  // operation select bit 1
  logic        btnr;  // operation select bit 0
  logic [15:0] sw;    // second operand B
  logic [15:0] led;   // current accumulator value

  modport master (
    output btnd, btnl, btnc, btnr, sw,
    input  led
  );

  modport slave (
    input  btnd, btnl, btnc, btnr, sw,
    output led
  );
endinterface

// File: rtl/calc_accumulator.sv
// Sixteen-bit accumulator calculator: button decoder, combinational ALU and
// accumulator register driving the LEDs.
// Optional feature: define CALC_BTND_SYNC_EN to pass btnd through a 2-flop
// synchronizer and rising-edge detector so each press updates exactly once.
module calc_accumulator (
  input  logic              clk,
  input  logic              btnu,   // asynchronous active-high reset
  calc_accumulator_if.slave bus
);

  typedef enum logic [2:0] {
    OP_AND = 3'b000,
    OP_OR  = 3'b001,
    OP_ADD = 3'b010,
    OP_SUB = 3'b011,
    OP_XOR = 3'b100,
    OP_SLT = 3'b101,
    OP_SLL = 3'b110,
    OP_SRA = 3'b111
  } op_e;

  op_e                op;
  logic signed [31:0] a_ext;
  logic signed [31:0] b_ext;
  logic        [4:0]  shamt;
  logic        [15:0] alu_res;
  logic        [15:0] acc_q;
  logic        [15:0] acc_d;
  logic               strobe;

  assign op    = op_e'({bus.btnl, bus.btnc, bus.btnr});
  assign a_ext = {{16{acc_q[15]}}, acc_q};
  assign b_ext = {{16{bus.sw[15]}}, bus.sw};
  assign shamt = bus.sw[4:0];

`ifdef CALC_BTND_SYNC_EN
  logic sync1_q;
  logic sync2_q;
  logic prev_q;

  // Synchronize btnd into clk and keep one delayed copy for edge detection.
  always_ff @(posedge clk or posedge btnu) begin
    if (btnu) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      prev_q  <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments make every flop sample its pre-edge
      // input, so this chain really is three stages and not one wire.
      sync1_q <= bus.btnd;
      sync2_q <= sync1_q;
      prev_q  <= sync2_q;
    end
  end

  // One-cycle pulse on each synchronized 0->1 transition of btnd.
  assign strobe = sync2_q & ~prev_q;
`else
  // btnd is a plain level enable: every edge it is high applies the op.
  assign strobe = bus.btnd;
`endif

  // 32-bit signed ALU; only the low 16 bits are kept, which gives modulo-2^16
  // wrap for ADD/SUB and 0 / all-sign-bits for shifts of 16 or more.
  always_comb begin
    // NOTE: a default before the case keeps this purely combinational even if
    // an arm is ever left without an assignment (no inferred latch).
    alu_res = 16'h0000;
    unique case (op)
      OP_AND: alu_res = 16'(a_ext & b_ext);
      OP_OR:  alu_res = 16'(a_ext | b_ext);
      OP_ADD: alu_res = 16'(a_ext + b_ext);
      OP_SUB: alu_res = 16'(a_ext - b_ext);
      OP_XOR: alu_res = 16'(a_ext ^ b_ext);
      OP_SLT: alu_res = {15'b0, (a_ext < b_ext)};
      OP_SLL: alu_res = 16'(a_ext << shamt);
      OP_SRA: alu_res = 16'(a_ext >>> shamt);
      default: alu_res = 16'h0000;
    endcase
  end

  // Next accumulator value: ALU result on an accepted strobe, else hold.
  always_comb begin
    acc_d = acc_q;
    if (strobe) acc_d = alu_res;
  end

  // Accumulator register; reset clears it immediately and overrides btnd.
  always_ff @(posedge clk or posedge btnu) begin
    if (btnu) acc_q <= 16'h0000;
    else      acc_q <= acc_d;
  end

  assign bus.led = acc_q;

endmodule

// File: tb/tb_calc_accumulator.sv
// Self-checking bench for calc_accumulator: a behavioural model compared on
// every falling edge, plus literal expectations from hand-computed vectors.
module tb_calc_accumulator;

  logic clk;
  logic btnu;
  calc_accumulator_if bus ();

  calc_accumulator dut (
    .clk  (clk),
    .btnu (btnu),
    .bus  (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;
  bit cmp_en   = 1'b0;

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: led=%h expected=%h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  function automatic logic [15:0] ref_op(input logic [2:0] op, input logic [15:0] acc,
                                         input logic [15:0] b);
    int sa;
    int sb;
    int sh;
    int r;
    sa = $signed(acc);
    sb = $signed(b);
    sh = int'(b[4:0]);
    case (op)
      3'd0: r = sa & sb;
      3'd1: r = sa | sb;
      3'd2: r = sa + sb;
      3'd3: r = sa - sb;
      3'd4: r = sa ^ sb;
      3'd5: r = (sa < sb) ? 1 : 0;
      3'd6: r = (sh >= 16) ? 0 : (sa << sh);
      default: r = (sh >= 16) ? ((sa < 0) ? -1 : 0) : (sa >>> sh);
    endcase
    return r[15:0];
  endfunction

  logic [15:0] model_acc = 16'h0000;
  logic [2:0]  btnd_hist = 3'b000;  // btnd seen at the last three edges, [0] newest

  always @(posedge clk or posedge btnu) begin
    logic take;
    if (btnu) begin
      model_acc = 16'h0000;
      btnd_hist = 3'b000;
    end else begin
`ifdef CALC_BTND_SYNC_EN
      take = btnd_hist[1] & ~btnd_hist[2];
`else
      take = bus.btnd;
`endif
      if (take)
        model_acc = ref_op({bus.btnl, bus.btnc, bus.btnr}, model_acc, bus.sw);
      btnd_hist = {btnd_hist[1:0], bus.btnd};
    end
  end

  always @(negedge clk) begin
    if (cmp_en) check("model", bus.led, model_acc);
  end

  // ---------------- stimulus helpers (all start and end at posedge+2) ----------------
  task automatic strobe_op(input logic [2:0] op, input logic [15:0] b);
    {bus.btnl, bus.btnc, bus.btnr} = op;
    bus.sw   = b;
    bus.btnd = 1'b1;
    @(posedge clk); #2;
    bus.btnd = 1'b0;
`ifdef CALC_BTND_SYNC_EN
    repeat (2) begin @(posedge clk); #2; end
`endif
  endtask

  task automatic reset_pulse();
    btnu = 1'b1;
    #1 check("rst_async", bus.led, 16'h0000);
    #1 btnu = 1'b0;
  endtask

  task automatic load(input logic [15:0] v);
    reset_pulse();
    strobe_op(3'b010, v);
  endtask

  logic [15:0] held;

  initial begin
    btnu     = 1'b1;
    bus.btnd = 1'b0;
    bus.btnl = 1'b0;
    bus.btnc = 1'b0;
    bus.btnr = 1'b0;
    bus.sw   = 16'h0000;
    @(posedge clk); #2;
    cmp_en = 1'b1;
    check("reset_state", bus.led, 16'h0000);
    @(posedge clk); #2;
    btnu = 1'b0;

    // Reset: load 0x1234 then pulse btnu between edges.
    strobe_op(3'b010, 16'h1234);
    check("load_1234", bus.led, 16'h1234);
    reset_pulse();
    // Reset while btnd held high.
    strobe_op(3'b010, 16'h1234);
    bus.btnd = 1'b1;
    btnu     = 1'b1;
    repeat (3) begin @(posedge clk); #1 check("rst_over_btnd", bus.led, 16'h0000); #1; end
    btnu     = 1'b0;
    bus.btnd = 1'b0;

    // ADD then SUB, logic chain.
    reset_pulse();
    strobe_op(3'b010, 16'h1234); check("add", bus.led, 16'h1234);
    strobe_op(3'b011, 16'h0FF0); check("sub", bus.led, 16'h0244);
    strobe_op(3'b001, 16'h324F); check("or",  bus.led, 16'h324F);
    strobe_op(3'b100, 16'hFFFF); check("xor", bus.led, 16'hCDB0);
    strobe_op(3'b000, 16'h0FF0); check("and", bus.led, 16'h0DB0);

    // ADD / SUB wrap.
    load(16'h7FFF);
    strobe_op(3'b010, 16'h0001); check("add_wrap", bus.led, 16'h8000);
    reset_pulse();
    strobe_op(3'b011, 16'h0001); check("sub_wrap", bus.led, 16'hFFFF);

    // SLT and shifts.
    load(16'hCDB0);
    strobe_op(3'b101, 16'h7346); check("slt_signed", bus.led, 16'h0001);
    strobe_op(3'b110, 16'h0004); check("sll_after_slt", bus.led, 16'h0010);
    strobe_op(3'b101, 16'h0001); check("slt_false", bus.led, 16'h0000);
    load(16'h8000);
    strobe_op(3'b111, 16'h0004); check("sra_4", bus.led, 16'hF800);
    strobe_op(3'b111, 16'h0014); check("sra_20", bus.led, 16'hFFFF);
    load(16'h1234);
    strobe_op(3'b110, 16'h0004); check("sll_4", bus.led, 16'h2340);
    load(16'h1234);
    strobe_op(3'b110, 16'h0014); check("sll_20", bus.led, 16'h0000);

    // Hold: no strobe, buttons and sw toggling for 10 cycles.
    load(16'h0244);
    held = bus.led;
    for (int i = 0; i < 10; i++) begin
      {bus.btnl, bus.btnc, bus.btnr} = 3'(i);
      case (i % 3)
        0: bus.sw = 16'hFFFF;
        1: bus.sw = 16'h0000;
        default: bus.sw = 16'h7346;
      endcase
      @(posedge clk); #2;
      check("hold", bus.led, held);
    end

    // Strobe count: btnd held for 3 edges with ADD 1 from 0.
    reset_pulse();
    {bus.btnl, bus.btnc, bus.btnr} = 3'b010;
    bus.sw   = 16'h0001;
    bus.btnd = 1'b1;
    @(posedge clk); #2;
`ifdef CALC_BTND_SYNC_EN
    check("sync_edge1", bus.led, 16'h0000);
    @(posedge clk); #2;
    check("sync_edge2", bus.led, 16'h0000);
    @(posedge clk); #2;
    bus.btnd = 1'b0;
    check("sync_edge3", bus.led, 16'h0001);
    repeat (4) begin @(posedge clk); #2; end
    check("sync_once", bus.led, 16'h0001);
    // Reset before the update lands discards it.
    bus.btnd = 1'b1;
    @(posedge clk); #2;
    bus.btnd = 1'b0;
    reset_pulse();
    repeat (4) begin @(posedge clk); #2; end
    check("sync_discard", bus.led, 16'h0000);
`else
    check("level_edge1", bus.led, 16'h0001);
    @(posedge clk); #2;
    check("level_edge2", bus.led, 16'h0002);
    @(posedge clk); #2;
    bus.btnd = 1'b0;
    check("level_edge3", bus.led, 16'h0003);
    repeat (2) begin @(posedge clk); #2; end
    check("level_hold", bus.led, 16'h0003);
`endif

    @(posedge clk); #2;
    cmp_en = 1'b0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
